// File: rtl/delay_arb_pkg.sv
// rtl/delay_arb_pkg.sv - shared state encoding and default sizing for the delay arbiter
package delay_arb_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int CLK_PER_US_DEF = 20;
  localparam int DLY_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_arbiter_if.sv
// rtl/delay_arbiter_if.sv - request/grant bundle between requesters and the delay arbiter
interface delay_arbiter_if
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DLY_W = DLY_W_DEF
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*DLY_W-1:0] dly_us;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   tick_1us;

  modport master (
    output req, dly_us,
    input  gnt, done, busy, tick_1us
  );

  modport slave (
    input  req, dly_us,
    output gnt, done, busy, tick_1us
  );

endinterface

// File: rtl/delay_arbiter_rr_select.sv
// rtl/delay_arbiter_rr_select.sv - combinational round-robin pick starting at ptr
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] index
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    onehot  = '0;
    index   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found           = 1'b1;
        onehot[pos_idx] = 1'b1;
        index           = pos_idx;
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// rtl/delay_arbiter.sv - shared microsecond timebase granted to one requester at a time
// DELAY_ARB_RR_EN selects round-robin; without it the lowest requesting index always wins.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int DLY_W      = DLY_W_DEF
) (
  input logic             clk,
  input logic             rst,
  delay_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int PS_W  = idx_width(CLK_PER_US);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel_idx;
  logic [N_REQ-1:0] sel_onehot;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic [DLY_W-1:0] remaining;
  logic [PS_W-1:0]  prescaler;
  logic             grant_now;
  logic             finish;
  logic             leave_run;
  logic             owner_req;
  logic             tick;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (sel_onehot),
    .index  (sel_idx)
  );

`ifdef DELAY_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_now) begin
      ptr <= (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  assign owner_req = bus.req[winner];
  // A zero-length delay never ticks; it just spends one granted cycle.
  assign tick = (state == RUN) && owner_req && (remaining != '0) &&
                (prescaler == PS_W'(CLK_PER_US - 1));

  always_comb begin
    state_next = state;
    grant_now  = 1'b0;
    finish     = 1'b0;
    leave_run  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_now  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // An abort still passes through DONE so busy covers one gnt-free cycle.
        if (!owner_req) begin
          leave_run  = 1'b1;
          state_next = DONE;
        end else if ((remaining == '0) || (tick && (remaining == DLY_W'(1)))) begin
          finish     = 1'b1;
          leave_run  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      winner    <= '0;
      remaining <= '0;
      prescaler <= '0;
    end else begin
      state  <= state_next;
      done_q <= finish ? gnt_q : '0;
      if (grant_now) begin
        gnt_q     <= sel_onehot;
        winner    <= sel_idx;
        remaining <= bus.dly_us[sel_idx*DLY_W +: DLY_W];
        prescaler <= '0;
      end else if (state == RUN) begin
        if (leave_run) begin
          gnt_q     <= '0;
          prescaler <= '0;
        end else begin
          prescaler <= (prescaler == PS_W'(CLK_PER_US - 1)) ? '0 : prescaler + 1'b1;
          if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != IDLE);
  assign bus.tick_1us = tick;

endmodule

// File: tb/tb_delay_arbiter.sv
// tb/tb_delay_arbiter.sv - directed self-checking bench for delay_arbiter
module tb_delay_arbiter;
  import delay_arb_pkg::*;

  localparam int N   = 4;
  localparam int CPU = 20;
  localparam int DW  = 8;
`ifdef DELAY_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  delay_arbiter_if #(.N_REQ(N), .DLY_W(DW)) bus ();

  delay_arbiter #(
    .N_REQ      (N),
    .CLK_PER_US (CPU),
    .DLY_W      (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_dly(input int i, input logic [DW-1:0] v);
    bus.dly_us[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.req    = '0;
    bus.dly_us = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tick", bus.tick_1us, 0);
    rst = 1'b0;
  endtask

  // Cycle c counts from the first cycle after the granting edge.
  task automatic expect_grant(input string tag, input int who, input int d,
                              input logic [N-1:0] clear_mask, input logic [N-1:0] set_mask);
    int         g;
    logic [N-1:0] oh;
    g  = (d == 0) ? 1 : d * CPU;
    oh = N'(1) << who;
    for (int c = 1; c <= g + 2; c++) begin
      @(negedge clk);
      check({tag, "_gnt"},  bus.gnt,  (c <= g) ? oh : '0);
      check({tag, "_tick"}, bus.tick_1us, (d > 0) && (c <= g) && (c % CPU == 0));
      check({tag, "_done"}, bus.done, (c == g + 1) ? oh : '0);
      check({tag, "_busy"}, bus.busy, c <= g + 1);
      if (c == 2 && set_mask != '0) begin
        bus.req    = bus.req | set_mask;
        bus.dly_us = '1;
      end
      if (c == g + 1) begin
        bus.req = bus.req & ~clear_mask;
      end
    end
  endtask

  initial begin
    bus.req    = '0;
    bus.dly_us = '0;

    do_reset();
    set_dly(0, 3);
    bus.req = 4'b0001;
    expect_grant("d3", 0, 3, 4'b0001, '0);

    do_reset();
    for (int i = 0; i < N; i++) set_dly(i, 1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_grant("order", RR_EN ? (k % N) : 0, 1, (k == 4) ? 4'b1111 : 4'b0000, '0);
    end

    do_reset();
    set_dly(0, 5);
    bus.req = 4'b0001;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      check("abort_gnt",  bus.gnt, (c <= 30) ? 4'b0001 : 4'b0000);
      check("abort_tick", bus.tick_1us, c == 20);
      check("abort_done", bus.done, 0);
      check("abort_busy", bus.busy, c <= 31);
      if (c == 30) bus.req = '0;
    end

    do_reset();
    set_dly(0, 9);
    set_dly(2, 0);
    bus.req = 4'b0100;
    expect_grant("d0", 2, 0, 4'b0100, '0);

    do_reset();
    set_dly(1, 2);
    bus.req = 4'b0010;
    expect_grant("latched", 1, 2, 4'b1111, 4'b1001);

    do_reset();
    set_dly(0, 3);
    bus.req = 4'b0001;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      check("pre_rst_gnt", bus.gnt, 4'b0001);
    end
    rst = 1'b1;
    #1;
    check("async_gnt",  bus.gnt, 0);
    check("async_done", bus.done, 0);
    check("async_busy", bus.busy, 0);
    check("async_tick", bus.tick_1us, 0);
    bus.req = 4'b1010;
    set_dly(1, 1);
    set_dly(3, 1);
    @(negedge clk);
    check("held_rst_done", bus.done, 0);
    check("held_rst_gnt",  bus.gnt, 0);
    rst = 1'b0;
    expect_grant("post_rst", 1, 1, 4'b1010, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the timebase.
REQ-002 Parameter CLK_PER_US, default 20, clk cycles per microsecond (20 MHz clk).
REQ-003 Parameter DLY_W, default 8, width of each requested delay in microseconds.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester delay request, level, held until done or abandoned.
REQ-007 dly_us  input  N_REQ*DLY_W  packed per-requester delay in microseconds; slice i belongs to req[i].
REQ-008 gnt  output  N_REQ  one-hot grant, registered; high while the owner's delay runs.
REQ-009 done  output  N_REQ  one-hot, one-cycle completion pulse, registered.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 tick_1us  output  1  one-cycle pulse at each elapsed microsecond of the active delay.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 In IDLE with any req bit high at edge t, the arbiter SHALL select one winner, assert its gnt from t+1, latch its dly_us slice into remaining, clear the prescaler and enter RUN.
REQ-014 Winner selection SHALL be round-robin starting at pointer ptr; on grant, ptr SHALL become (winner+1) mod N_REQ.
REQ-015 The prescaler SHALL count 0..CLK_PER_US-1 in RUN; tick_1us SHALL pulse when it equals CLK_PER_US-1, then wrap to 0.
REQ-016 Each tick SHALL decrement remaining; the tick that takes remaining from 1 to 0 SHALL move the FSM to DONE.
REQ-017 In DONE, gnt SHALL be all-zero, done[winner] SHALL be high for exactly one cycle, and the next state SHALL be IDLE.
REQ-018 gnt duration for delay D>0 SHALL be exactly D*CLK_PER_US cycles; done appears the cycle after gnt falls.
REQ-019 Delay D=0 SHALL give gnt for one cycle, then DONE with no tick_1us.
REQ-020 If req[winner] is low during RUN, the block SHALL abort: gnt low, no done, no tick, return to IDLE next cycle.
REQ-021 req changes of non-winners and dly_us changes after latching SHALL not affect the active delay.
REQ-022 After DONE or abort, at least one IDLE cycle SHALL occur before the next grant; a held req is re-arbitrated normally.
REQ-023 At most one gnt bit and one done bit SHALL be high in any cycle; gnt and done SHALL never overlap.

Reset
REQ-024 On rst: state IDLE, gnt=0, done=0, busy=0, tick_1us=0, prescaler=0, remaining=0, ptr=0.
REQ-025 rst mid-RUN SHALL abort immediately with no done pulse; first grant after release uses ptr=0.

Configuration
REQ-026 Macro DELAY_ARB_RR_EN defined: round-robin per REQ-014.
REQ-027 Macro DELAY_ARB_RR_EN undefined: fixed priority, lowest index wins, ptr logic absent; all other behaviour unchanged.

Structure
REQ-028 A shared package delay_arb_pkg SHALL hold the state encoding (IDLE/RUN/DONE) and default constants (N_REQ, CLK_PER_US, DLY_W).
REQ-029 Round-robin/priority selection SHALL be a sub-module rr_select (req, ptr in; one-hot winner and index out, combinational).
REQ-030 The prescaler and remaining counter SHALL stay inside delay_arbiter.

Verification (CLK_PER_US=20, N_REQ=4, rst-then-release)
REQ-031 req=0001, dly0=3 at edge t -> gnt=0001 t+1..t+60, tick_1us at t+20,t+40,t+60, done=0001 at t+61, busy low at t+62.
REQ-032 req=1111 held, all dly=1 (RR_EN) -> grant order 0,1,2,3,0; each gnt 20 cycles, one IDLE cycle between done and next gnt.
REQ-033 Same as REQ-032 without DELAY_ARB_RR_EN -> every grant to requester 0.
REQ-034 req0, dly0=5, drop req0 at gnt cycle 30 -> gnt low next cycle, no done pulse, busy low one cycle later.
REQ-035 req2, dly2=0 -> gnt=0100 one cycle, done=0100 next cycle, tick_1us never pulses.
REQ-036 rst asserted at gnt cycle 45 of a 3 us delay -> all outputs 0 asynchronously, no done; next request with req=1010 grants requester 1.
